// File: rtl/reset_seq_pkg.sv
// Shared types, timing defaults and helpers for the VM1 reset sequencer.
// Graceful power-fail is enabled with RESET_SEQ_GRACEFUL_PF_EN.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        S_HOLD,
        S_DCLO,
        S_ACLO,
        S_RUN,
        S_PFAIL
    } state_e;

    localparam int DCLO_CLK_DEF = 24;
    localparam int ACLO_CLK_DEF = 240;
    localparam int PF_CLK_DEF   = 64;

    function automatic int cnt_width(input int max_cnt);
        return $clog2(max_cnt + 1);
    endfunction

endpackage

// File: rtl/reset_src_sync.sv
// Multi-bit, multi-stage synchroniser for asynchronous reset requests.
// Every stage clears asynchronously on the active-high reset.
module reset_src_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;

    assign sync_d = {sync_q[STAGES-2:0], d_i};
    assign q_o    = sync_q[STAGES-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// PDP-11 style DCLO/ACLO power-up sequencer with maskable reset sources.
// Define RESET_SEQ_GRACEFUL_PF_EN for ACLO-first power-fail sequencing.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NSRC        = 3,
    parameter int SYNC_STAGES = 2,
    parameter int DCLO_CLK    = DCLO_CLK_DEF,
    parameter int ACLO_CLK    = ACLO_CLK_DEF,
    parameter int PF_CLK      = PF_CLK_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic [NSRC-1:0] src_mask,
    input  logic            cause_clr,
    output logic            dclo,
    output logic            aclo,
    output logic            busy,
    output logic            ready,
    output logic [NSRC-1:0] cause
);

    if (NSRC < 1 || NSRC > 8) begin : g_bad_nsrc
        $error("reset_sequencer: NSRC must be 1..8");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("reset_sequencer: SYNC_STAGES must be >= 2");
    end
    if (DCLO_CLK < 1 || ACLO_CLK < 1 || PF_CLK < 1) begin : g_bad_tim
        $error("reset_sequencer: timing parameters must be >= 1");
    end

    localparam int MAX_DA = (DCLO_CLK > ACLO_CLK) ? DCLO_CLK : ACLO_CLK;
`ifdef RESET_SEQ_GRACEFUL_PF_EN
    localparam int MAX_CNT = (PF_CLK > MAX_DA) ? PF_CLK : MAX_DA;
`else
    localparam int MAX_CNT = MAX_DA;
`endif
    localparam int CW = cnt_width(MAX_CNT);

    localparam logic [CW-1:0] DCLO_LAST = CW'(DCLO_CLK - 1);
    localparam logic [CW-1:0] ACLO_LAST = CW'(ACLO_CLK - 1);
`ifdef RESET_SEQ_GRACEFUL_PF_EN
    localparam logic [CW-1:0] PF_LAST   = CW'(PF_CLK - 1);
`endif

    logic [NSRC-1:0] src_sync;
    logic [NSRC-1:0] src_act;
    logic            req;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dclo_q, dclo_d;
    logic            aclo_q, aclo_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic [NSRC-1:0] cause_q, cause_d;

    reset_src_sync #(
        .WIDTH  (NSRC),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (src),
        .q_o   (src_sync)
    );

    assign src_act = src_sync & src_mask;
    assign req     = |src_act;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dclo_d  = dclo_q;
        aclo_d  = aclo_q;
        ready_d = 1'b0;
        // A set in the same cycle as a clear keeps the new bit
        cause_d = (cause_clr ? '0 : cause_q) | src_act;

        unique case (state_q)
            S_HOLD: begin
                dclo_d = 1'b1;
                aclo_d = 1'b1;
                if (!req) begin
                    state_d = S_DCLO;
                    cnt_d   = '0;
                end
            end
            S_DCLO: begin
                if (req) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == DCLO_LAST) begin
                    dclo_d  = 1'b0;
                    state_d = S_ACLO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACLO: begin
                if (req) begin
                    dclo_d  = 1'b1;
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == ACLO_LAST) begin
                    aclo_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (req) begin
                    aclo_d = 1'b1;
                    cnt_d  = '0;
`ifdef RESET_SEQ_GRACEFUL_PF_EN
                    state_d = S_PFAIL;
`else
                    dclo_d  = 1'b1;
                    state_d = S_HOLD;
`endif
                end
            end
`ifdef RESET_SEQ_GRACEFUL_PF_EN
            // Power-down always runs to completion once started
            S_PFAIL: begin
                if (cnt_q == PF_LAST) begin
                    dclo_d  = 1'b1;
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: begin
                dclo_d  = 1'b1;
                aclo_d  = 1'b1;
                state_d = S_HOLD;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            dclo_q  <= 1'b1;
            aclo_q  <= 1'b1;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dclo_q  <= dclo_d;
            aclo_q  <= aclo_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            cause_q <= cause_d;
        end
    end

    assign dclo  = dclo_q;
    assign aclo  = aclo_q;
    assign busy  = busy_q;
    assign ready = ready_q;
    assign cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer against a timeline reference model.
// Honours RESET_SEQ_GRACEFUL_PF_EN for the power-fail expectations.
module tb_reset_sequencer;

    localparam int NSRC = 3;
    localparam int SYNC = 2;
    localparam int DCLO = 4;
    localparam int ACLO = 8;
    localparam int PF   = 6;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NSRC-1:0] src = '0;
    logic [NSRC-1:0] src_mask = 3'b111;
    logic            cause_clr = 1'b0;
    logic            dclo, aclo, busy, ready;
    logic [NSRC-1:0] cause;

    int checks = 0;
    int errors = 0;

    reset_sequencer #(
        .NSRC        (NSRC),
        .SYNC_STAGES (SYNC),
        .DCLO_CLK    (DCLO),
        .ACLO_CLK    (ACLO),
        .PF_CLK      (PF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .src       (src),
        .src_mask  (src_mask),
        .cause_clr (cause_clr),
        .dclo      (dclo),
        .aclo      (aclo),
        .busy      (busy),
        .ready     (ready),
        .cause     (cause)
    );

    always #5 clk = ~clk;

    // Model: one elapsed-edge timer per phase instead of per-state counters
    localparam int MH = 0;
    localparam int MU = 1;
    localparam int MR = 2;
    localparam int MP = 3;

    logic [NSRC-1:0] hist[$];
    int              mode;
    int              e;
    logic            m_ready;
    logic [NSRC-1:0] m_cause;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < SYNC; i++) hist.push_back('0);
        mode    = MH;
        e       = 0;
        m_ready = 1'b0;
        m_cause = '0;
    endtask

    task automatic model_edge();
        logic [NSRC-1:0] s;
        logic            r;
        s = hist.pop_front();
        hist.push_back(src);
        r = |(s & src_mask);
        m_cause = (cause_clr ? '0 : m_cause) | (s & src_mask);
        m_ready = 1'b0;
        case (mode)
            MH: if (!r) begin mode = MU; e = 0; end
            MU: begin
                if (r) mode = MH;
                else begin
                    e++;
                    if (e == DCLO + ACLO) begin
                        mode = MR;
                        m_ready = 1'b1;
                    end
                end
            end
            MR: if (r) begin
`ifdef RESET_SEQ_GRACEFUL_PF_EN
                mode = MP;
                e = 0;
`else
                mode = MH;
`endif
            end
            default: begin
                e++;
                if (e == PF) mode = MH;
            end
        endcase
    endtask

    function automatic logic m_dclo();
        return (mode == MH) || (mode == MU && e < DCLO);
    endfunction

    function automatic logic m_aclo();
        return (mode != MR);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string t);
        chk({t, ".dclo"}, 8'(dclo), 8'(m_dclo()));
        chk({t, ".aclo"}, 8'(aclo), 8'(m_aclo()));
        chk({t, ".busy"}, 8'(busy), 8'(mode != MR));
        chk({t, ".ready"}, 8'(ready), 8'(m_ready));
        chk({t, ".cause"}, 8'(cause), 8'(m_cause));
    endtask

    task automatic step(input string t);
        @(posedge clk);
        model_edge();
        #1;
        check_all(t);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        model_reset();
        check_all("rst");
        reset = 1'b0;
        #1;
    endtask

    initial begin
        model_reset();
        #7;
        check_all("por");
        reset = 1'b0;

        // Scenario 1: power-up timing
        for (int k = 1; k <= 14; k++) begin
            step("s1");
            if (k == 4)  chk("s1_dclo_e4", 8'(dclo), 8'd1);
            if (k == 5)  chk("s1_dclo_e5", 8'(dclo), 8'd0);
            if (k == 12) chk("s1_aclo_e12", 8'(aclo), 8'd1);
            if (k == 13) chk("s1_ready_e13", 8'(ready), 8'd1);
            if (k == 13) chk("s1_aclo_e13", 8'(aclo), 8'd0);
            if (k == 14) chk("s1_ready_e14", 8'(ready), 8'd0);
        end
        chk("s1_cause", 8'(cause), 8'd0);

        // Scenario 2: restart from S_ACLO
        do_reset();
        repeat (7) step("s2a");
        src = 3'b010;
        for (int k = 1; k <= 3; k++) begin
            step("s2b");
            if (k == 3) chk("s2_hold_dclo", 8'(dclo), 8'd1);
        end
        src = 3'b000;
        step("s2c");
        step("s2c");
        chk("s2_cause", 8'(cause), 8'd2);
        repeat (4) step("s2d");
        chk("s2_dclo_e9", 8'(dclo), 8'd1);
        step("s2e");
        chk("s2_dclo_e10", 8'(dclo), 8'd0);
        repeat (8) step("s2f");
        chk("s2_aclo_e18", 8'(aclo), 8'd0);
        repeat (2) step("s2g");

        // Scenario 3: power-fail from S_RUN
        src = 3'b001;
        for (int k = 1; k <= 4; k++) begin
            step("s3a");
            if (k == 2) chk("s3_aclo_e2", 8'(aclo), 8'd0);
            if (k == 3) chk("s3_aclo_e3", 8'(aclo), 8'd1);
`ifndef RESET_SEQ_GRACEFUL_PF_EN
            if (k == 3) chk("s3_dclo_e3", 8'(dclo), 8'd1);
`endif
        end
        src = 3'b000;
        for (int k = 5; k <= 9; k++) begin
            step("s3b");
`ifdef RESET_SEQ_GRACEFUL_PF_EN
            if (k == 8) chk("s3_dclo_e8", 8'(dclo), 8'd0);
            if (k == 9) chk("s3_dclo_e9", 8'(dclo), 8'd1);
`endif
        end
        repeat (24) step("s3c");

        // Scenario 4: masked source toggling in S_RUN
        src_mask = 3'b110;
        for (int k = 0; k < 10; k++) begin
            src[0] = ~src[0];
            step("s4");
            chk("s4_dclo", 8'(dclo), 8'd0);
            chk("s4_aclo", 8'(aclo), 8'd0);
        end
        src[0] = 1'b0;
        repeat (3) step("s4b");
        src_mask = 3'b111;
        step("s4c");

        // Scenario 5: async reset mid-S_ACLO
        do_reset();
        repeat (9) step("s5a");
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("s5_async");
        chk("s5_busy", 8'(busy), 8'd1);
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            step("s5b");
            if (k == 5)  chk("s5_dclo_e5", 8'(dclo), 8'd0);
            if (k == 13) chk("s5_ready_e13", 8'(ready), 8'd1);
        end

        // Scenario 6: clear and set in the same cycle
        cause_clr = 1'b1;
        step("s6a");
        cause_clr = 1'b0;
        src = 3'b001;
        repeat (3) step("s6b");
        src = 3'b000;
        repeat (3) step("s6c");
        chk("s6_cause_pre", 8'(cause), 8'd1);
        src = 3'b100;
        repeat (2) step("s6d");
        cause_clr = 1'b1;
        step("s6e");
        chk("s6_cause_post", 8'(cause), 8'd4);
        cause_clr = 1'b0;
        src = 3'b000;
        repeat (20) step("s6f");

        // Random phase: sparse request pulses, mask and clear activity
        for (int i = 0; i < 2000; i++) begin
            if (src != '0) begin
                if ($urandom_range(0, 3) == 0) src = '0;
            end else if ($urandom_range(0, 49) == 0) begin
                src[$urandom_range(0, NSRC - 1)] = 1'b1;
            end
            if ($urandom_range(0, 199) == 0) src_mask = NSRC'($urandom);
            cause_clr = ($urandom_range(0, 31) == 0);
            step("rnd");
            if (i == 1000) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
